// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit little-endian words from four byte reads on a shared
// byte port. One finished word can be parked while decode stalls, and decode jumps redirect fetch.
//
// state  | meaning
// S_B0   | request the port; issue fetch_pc+0 once granted
// S_B1   | issue fetch_pc+1, capture byte 0
// S_B2   | issue fetch_pc+2, capture byte 1
// S_B3   | issue fetch_pc+3, capture byte 2
// S_DONE | capture byte 3; load the output if it is free, else park the word
// S_FULL | word parked; load it as soon as decode consumes the current one
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    input  logic        mem_grant_i,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [2:0] {
        S_B0   = 3'd0,
        S_B1   = 3'd1,
        S_B2   = 3'd2,
        S_B3   = 3'd3,
        S_DONE = 3'd4,
        S_FULL = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  b0_nxt, b1_nxt, b2_nxt;
    logic [31:0] held, held_nxt;
    logic [31:0] pc_nxt, inst_nxt;
    logic        valid_nxt;
    logic        req;
    logic [31:0] addr;
    logic        out_free;
    logic        consume;
    logic        load;
    logic [31:0] load_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_B0;
            fetch_pc     <= RESET_PC;
            b0           <= '0;
            b1           <= '0;
            b2           <= '0;
            held         <= '0;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            b0           <= b0_nxt;
            b1           <= b1_nxt;
            b2           <= b2_nxt;
            held         <= held_nxt;
            pc_o         <= pc_nxt;
            inst_o       <= inst_nxt;
            inst_valid_o <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        b0_nxt       = b0;
        b1_nxt       = b1;
        b2_nxt       = b2;
        held_nxt     = held;
        pc_nxt       = pc_o;
        inst_nxt     = inst_o;
        valid_nxt    = inst_valid_o;
        req          = 1'b0;
        addr         = '0;
        load         = 1'b0;
        load_word    = '0;
        out_free     = !inst_valid_o || !stall_i;
        consume      = inst_valid_o && !stall_i;

        case (state)
            S_B0: begin
                req = 1'b1;
                if (mem_grant_i) begin
                    addr      = fetch_pc;
                    state_nxt = S_B1;
                end
            end
            S_B1: begin
                req       = 1'b1;
                addr      = fetch_pc + 32'd1;
                b0_nxt    = mem_din_i;
                state_nxt = S_B2;
            end
            S_B2: begin
                req       = 1'b1;
                addr      = fetch_pc + 32'd2;
                b1_nxt    = mem_din_i;
                state_nxt = S_B3;
            end
            S_B3: begin
                req       = 1'b1;
                addr      = fetch_pc + 32'd3;
                b2_nxt    = mem_din_i;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_word = {mem_din_i, b2, b1, b0};
                    state_nxt = S_B0;
                end else begin
                    held_nxt  = {mem_din_i, b2, b1, b0};
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_word = held;
                    state_nxt = S_B0;
                end
            end
            default: state_nxt = S_B0;
        endcase

        // fetch_pc still addresses the word being loaded, so it becomes pc_o before advancing
        if (load) begin
            pc_nxt       = fetch_pc;
            inst_nxt     = load_word;
            valid_nxt    = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
        end else if (consume) begin
            pc_nxt    = '0;
            inst_nxt  = '0;
            valid_nxt = 1'b0;
        end

        if (jump_i) begin
            fetch_pc_nxt = jump_addr_i & 32'hFFFF_FFFE;
            pc_nxt       = '0;
            inst_nxt     = '0;
            valid_nxt    = 1'b0;
            b0_nxt       = '0;
            b1_nxt       = '0;
            b2_nxt       = '0;
            held_nxt     = '0;
            state_nxt    = S_B0;
        end
    end

    // The reset state is S_B0, which would otherwise request the port while rst_n is low
    assign mem_req_o  = rst_n & req;
    assign mem_addr_o = rst_n ? addr : 32'h0;

endmodule
